// File: rtl/dac_serial_pkg.sv
// Shared types, frame constants and sample conversion for the dual-DAC serializer.
package dac_serial_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, LDAC} state_e;

  localparam int   FRAME_W        = 17;
  localparam int   BITS_PER_FRAME = FRAME_W;
  localparam logic CH_LOW         = 1'b0;
  localparam logic CH_HIGH        = 1'b1;

  // Sign-magnitude to offset binary; negative zero lands on mid-scale.
  function automatic logic [15:0] sm_to_offset(input logic [15:0] sm);
    logic [15:0] mag;
    mag = {1'b0, sm[14:0]};
    return sm[15] ? (16'h8000 - mag) : (16'h8000 + mag);
  endfunction

endpackage

// File: rtl/dual_dac_serializer_tick.sv
// sclk_tick_gen: SCLK_DIV down-counter with sync clear; tick marks the last cycle of each phase.
module sclk_tick_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr)                cnt_d = '0;
    else if (cnt_q == '0)   cnt_d = CW'(SCLK_DIV - 1);
    else                    cnt_d = cnt_q - CW'(1);
  end

  // Sequence after clear is 0, DIV-1, ..., 1 so the tick lands on the DIV-th cycle.
  assign tick = (SCLK_DIV == 1) ? 1'b1 : (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dual_dac_serializer.sv
// Captures a low/high sample pair, sends two 17-bit SPI mode-0 frames, then pulses ldac_n.
// Define DAC_OVERRUN_CNT_EN to build the saturating dropped-pair counter; otherwise overrun_cnt is 0.
module dual_dac_serializer
  import dac_serial_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int OVR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      low_in,
  input  logic [15:0]      high_in,
  output logic             sclk,
  output logic             sdata,
  output logic             cs_n,
  output logic             ldac_n,
  output logic [OVR_W-1:0] overrun_cnt
);
  localparam logic [4:0] LAST_BIT = 5'(BITS_PER_FRAME - 1);

  state_e               state_q, state_d;
  logic                 ch_q, ch_d;
  logic [4:0]           bit_q, bit_d;
  logic                 half_q, half_d;
  logic [15:0]          lo_q, lo_d, hi_q, hi_d;
  logic                 sclk_q, sclk_d, sdata_q, sdata_d;
  logic                 cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
  logic                 in_ready_q, in_ready_d;
  logic [FRAME_W-1:0]   frame;
  logic                 tick;

  sclk_tick_gen #(.SCLK_DIV(SCLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    half_d  = half_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: if (in_valid) begin
        lo_d    = sm_to_offset(low_in);
        hi_d    = sm_to_offset(high_in);
        ch_d    = CH_LOW;
        state_d = SETUP;
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        bit_d   = '0;
        half_d  = 1'b0;
      end
      SHIFT: if (tick) begin
        if (!half_q)               half_d  = 1'b1;
        else if (bit_q == LAST_BIT) state_d = HOLD;
        else begin
          bit_d  = bit_q + 5'd1;
          half_d = 1'b0;
        end
      end
      HOLD: if (tick) state_d = (ch_q == CH_LOW) ? GAP : LDAC;
      GAP:  if (tick) begin
        state_d = SETUP;
        ch_d    = CH_HIGH;
      end
      LDAC: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so they are registered alongside it.
    frame   = {ch_d, (ch_d == CH_HIGH) ? hi_d : lo_d};
    sdata_d = sdata_q;
    case (state_d)
      IDLE:    sdata_d = 1'b0;
      SETUP:   sdata_d = frame[LAST_BIT];
      SHIFT:   sdata_d = frame[LAST_BIT - bit_d];
      default: sdata_d = sdata_q;
    endcase
    sclk_d     = (state_d == SHIFT) && half_d;
    cs_n_d     = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    ldac_n_d   = (state_d != LDAC);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= CH_LOW;
      bit_q      <= '0;
      half_q     <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= 1'b1;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      half_q     <= half_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      cs_n_q     <= cs_n_d;
      ldac_n_q   <= ldac_n_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef DAC_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (in_valid && !in_ready_q && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= '0;
    else     ovr_q <= ovr_d;
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

  assign in_ready = in_ready_q;
  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign cs_n     = cs_n_q;
  assign ldac_n   = ldac_n_q;

endmodule

// File: tb/tb_dual_dac_serializer.sv
// Scoreboard bench: two instances (SCLK_DIV=2 and 1) driven per cycle against a transaction-level model.
module tb_dual_dac_serializer;
  localparam int OVR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid[2], in_ready[2], sclk[2], sdata[2], cs_n[2], ldac_n[2];
  logic [15:0] low_in[2], high_in[2];
  logic [OVR_W-1:0] ovr[2];

  int checks = 0, passes = 0;
  int busy[2], drops[2], exp_pulses[2];
  logic [16:0] exp_q0[$], exp_q1[$];

  always #5 clk = ~clk;

  dual_dac_serializer #(.SCLK_DIV(2), .OVR_W(OVR_W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .low_in(low_in[0]), .high_in(high_in[0]), .sclk(sclk[0]), .sdata(sdata[0]),
    .cs_n(cs_n[0]), .ldac_n(ldac_n[0]), .overrun_cnt(ovr[0]));

  dual_dac_serializer #(.SCLK_DIV(1), .OVR_W(OVR_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .low_in(low_in[1]), .high_in(high_in[1]), .sclk(sclk[1]), .sdata(sdata[1]),
    .cs_n(cs_n[1]), .ldac_n(ldac_n[1]), .overrun_cnt(ovr[1]));

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  // Reference conversion straight from the arithmetic definition.
  function automatic logic [15:0] ref_conv(input logic [15:0] sm);
    int mag, v;
    mag = int'(sm[14:0]);
    v   = sm[15] ? 32768 - mag : 32768 + mag;
    return v[15:0];
  endfunction

  task automatic push_exp(input int i, input logic [16:0] f);
    if (i == 0) exp_q0.push_back(f);
    else        exp_q1.push_back(f);
  endtask

  function automatic logic [16:0] pop_exp(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic int exp_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int exp_ovr(input int i);
`ifdef DAC_OVERRUN_CNT_EN
    return (drops[i] > 255) ? 255 : drops[i];
`else
    return 0 + (i & 0);
`endif
  endfunction

  // Model: a pair occupies the block for 74*DIV cycles after its capture edge.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (busy[i] > 0) exp_pulses[i]--;
        busy[i]  = 0;
        drops[i] = 0;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (busy[i] > 0) begin
        if (in_valid[i]) drops[i]++;
        busy[i]--;
      end else if (in_valid[i]) begin
        push_exp(i, {1'b0, ref_conv(low_in[i])});
        push_exp(i, {1'b1, ref_conv(high_in[i])});
        busy[i] = 74 * div_of(i);
        exp_pulses[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    while (busy[0] > 0 || busy[1] > 0) step();
    repeat (4) step();
  endtask

  task automatic send_pair(input logic [15:0] lo, input logic [15:0] hi);
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b1; low_in[i] = lo; high_in[i] = hi;
    end
    step();
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; low_in[i] = 16'($urandom); high_in[i] = 16'($urandom);
    end
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_in_ready"}, i, in_ready[i], 1);
      check({tag, "_cs_n"},     i, cs_n[i],     1);
      check({tag, "_sclk"},     i, sclk[i],     0);
      check({tag, "_sdata"},    i, sdata[i],    0);
      check({tag, "_ldac_n"},   i, ldac_n[i],   1);
      check({tag, "_ovr"},      i, ovr[i],      0);
    end
  endtask

  task automatic burst(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'b1; low_in[i] = 16'($urandom); high_in[i] = 16'($urandom);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      check("overrun_cnt", i, ovr[i], exp_ovr(i));
    end
  endtask

  // Monitors: reassemble frames on sclk rising edges and time ldac_n / in_ready windows.
  for (genvar g = 0; g < 2; g++) begin : mon
    int nb = 0, lrun = 0, brun = 0, pulses = 0;
    logic [16:0] sh = '0;
    logic [16:0] e;
    logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_ldac = 1'b1, prev_rdy = 1'b1, last_ch = 1'b0;

    always @(negedge clk) begin
      if (rst) begin
        nb = 0; lrun = 0; brun = 0; sh = '0;
        prev_sclk = 1'b0; prev_cs = 1'b1; prev_ldac = 1'b1; prev_rdy = 1'b1;
      end else begin
        if (!cs_n[g] && sclk[g] && !prev_sclk) begin
          sh = {sh[15:0], sdata[g]};
          nb++;
        end
        if (cs_n[g] && !prev_cs) begin
          if (exp_size(g) == 0) check("frame_unexpected", g, sh, 32'hFFFF_FFFF);
          else begin
            e = pop_exp(g);
            check("frame_bits", g, nb, 17);
            check("frame", g, sh, e);
          end
          check("sclk_idle", g, sclk[g], 0);
          last_ch = sh[16];
          nb = 0;
        end
        if (!ldac_n[g]) lrun++;
        else if (!prev_ldac) begin
          check("ldac_len", g, lrun, div_of(g));
          check("ldac_after_high", g, last_ch, 1);
          pulses++;
          lrun = 0;
        end
        if (!in_ready[g]) brun++;
        else if (!prev_rdy) begin
          check("busy_window", g, brun, 74 * div_of(g));
          brun = 0;
        end
        prev_sclk = sclk[g]; prev_cs = cs_n[g]; prev_ldac = ldac_n[g]; prev_rdy = in_ready[g];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; low_in[i] = '0; high_in[i] = '0;
      busy[i] = 0; drops[i] = 0; exp_pulses[i] = 0;
    end
    rst = 1'b1;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    send_pair(16'h0003, 16'h80FC);
    send_pair(16'h7FFF, 16'hFFFF);
    send_pair(16'h0000, 16'h8000);

    burst(100);
    drain();

    // Abort both instances while frame0 bit 9 is on the wire.
    in_valid[0] = 1'b1; low_in[0] = 16'($urandom); high_in[0] = 16'($urandom);
    step();
    in_valid[0] = 1'b0;
    repeat (19) step();
    in_valid[1] = 1'b1; low_in[1] = 16'($urandom); high_in[1] = 16'($urandom);
    step();
    in_valid[1] = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    check_reset_outputs("abort");
    step();
    rst = 1'b0;
    step();
    send_pair(16'h1234, 16'h9ABC);

    burst(600);
    drain();

    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 15) == 0);
        low_in[i]   = 16'($urandom);
        high_in[i]  = 16'($urandom);
      end
      step();
    end
    drain();

    for (int i = 0; i < 2; i++) begin
      check("overrun_final", i, ovr[i], exp_ovr(i));
      check("frames_left", i, exp_size(i), 0);
    end
    check("ldac_pulses", 0, mon[0].pulses, exp_pulses[0]);
    check("ldac_pulses", 1, mon[1].pulses, exp_pulses[1]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
